// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared widths, coefficient type and reference PWL arithmetic for the Box-Muller evaluator
package bm_pkg;

   localparam int DEF_ADDR_W  = 7;
   localparam int DEF_BASE_W  = 20;
   localparam int DEF_SLOPE_W = 13;
   localparam int DEF_FRAC_W  = 8;

   typedef struct packed {
      logic [DEF_BASE_W-1:0]  base;
      logic [DEF_SLOPE_W-1:0] slope;
   } coef_t;

   // y = base + round_half_up(slope*frac / 2^FRAC_W), clamped to the BASE_W range
   function automatic logic [DEF_BASE_W-1:0] pwl_sat(
      input logic [DEF_BASE_W-1:0]  base,
      input logic [DEF_SLOPE_W-1:0] slope,
      input logic [DEF_FRAC_W-1:0]  frac
   );
      logic [DEF_SLOPE_W+DEF_FRAC_W-1:0] prod;
      logic [DEF_SLOPE_W-1:0]            inc;
      logic [DEF_BASE_W:0]               sum;
      prod = {{DEF_FRAC_W{1'b0}}, slope} * {{DEF_SLOPE_W{1'b0}}, frac};
      prod = prod + ((DEF_SLOPE_W+DEF_FRAC_W)'(1) << (DEF_FRAC_W-1));
      inc  = prod[DEF_SLOPE_W+DEF_FRAC_W-1:DEF_FRAC_W];
      sum  = {1'b0, base} + {{(DEF_BASE_W+1-DEF_SLOPE_W){1'b0}}, inc};
      return sum[DEF_BASE_W] ? {DEF_BASE_W{1'b1}} : sum[DEF_BASE_W-1:0];
   endfunction

endpackage

// File: rtl/bm_coef_ram.sv
// rtl/bm_coef_ram.sv - coefficient table, one write port, registered read with read-before-write
module bm_coef_ram #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 33
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Both updates are non-blocking, so a same-address read returns the pre-write entry
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/bm_pwl_eval.sv
// rtl/bm_pwl_eval.sv - 3-stage piecewise-linear evaluator with loadable {base, slope} table
module bm_pwl_eval
   import bm_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int BASE_W  = DEF_BASE_W,
   parameter int SLOPE_W = DEF_SLOPE_W,
   parameter int FRAC_W  = DEF_FRAC_W
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [ADDR_W-1:0]         cfg_addr,
   input  logic [BASE_W+SLOPE_W-1:0] cfg_wdata,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W+FRAC_W-1:0]  in_x,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BASE_W-1:0]         out_y
);

   localparam int DATA_W = BASE_W + SLOPE_W;
   localparam int PROD_W = SLOPE_W + FRAC_W;
   localparam logic [PROD_W-1:0] HALF = PROD_W'(1) << (FRAC_W-1);

   logic              stall;
   logic              s1_valid;
   logic [ADDR_W-1:0] s1_addr;
   logic [FRAC_W-1:0] s1_frac;
   logic              s2_valid;
   logic [FRAC_W-1:0] s2_frac;
   logic [DATA_W-1:0] rd_data;
   logic              rd_en;

   logic [BASE_W-1:0]  base;
   logic [SLOPE_W-1:0] slope;
   logic [PROD_W-1:0]  prod;
   logic [PROD_W-1:0]  rnd;
   logic [SLOPE_W-1:0] inc;
   logic [BASE_W:0]    sum;
   logic [BASE_W-1:0]  y_sat;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign rd_en    = ~stall;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_frac  <= '0;
         s2_valid <= 1'b0;
         s2_frac  <= '0;
      end else if (!stall) begin
         s1_valid <= in_valid;
         s1_addr  <= in_x[ADDR_W+FRAC_W-1:FRAC_W];
         s1_frac  <= in_x[FRAC_W-1:0];
         s2_valid <= s1_valid;
         s2_frac  <= s1_frac;
      end
   end

   // The RAM output register is the S2 {base, slope} stage; it freezes with the pipeline
   bm_coef_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .clock(clock),
      .we   (cfg_we),
      .waddr(cfg_addr),
      .wdata(cfg_wdata),
      .re   (rd_en),
      .raddr(s1_addr),
      .rdata(rd_data)
   );

   always_comb begin
      base  = rd_data[DATA_W-1:SLOPE_W];
      slope = rd_data[SLOPE_W-1:0];
      prod  = PROD_W'(slope) * PROD_W'(s2_frac);
      rnd   = prod + HALF;
      inc   = rnd[PROD_W-1:FRAC_W];
      sum   = (BASE_W+1)'(base) + (BASE_W+1)'(inc);
      y_sat = sum[BASE_W] ? {BASE_W{1'b1}} : sum[BASE_W-1:0];
   end

   // out_y only loads on real samples so bubbles never expose unwritten table entries
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_y     <= '0;
      end else if (!stall) begin
         out_valid <= s2_valid;
         if (s2_valid) out_y <= y_sat;
      end
   end

endmodule

// File: doc/bm_pwl_eval.md
Name: bm_pwl_eval

Overview:
- Parametrised piecewise-linear function evaluator for the Box-Muller datapath (sqrt / -ln / cos segments).
- Holds a runtime-loadable coefficient table of {base, slope} pairs and evaluates y = base[addr] + round(slope[addr]*frac / 2^FRAC_W).
- Generalises the fixed sqrt coefficient ROM: depth and widths are parametrised, the table is written through a config port, and evaluation is a 3-stage pipeline with valid/ready handshake and output saturation.

Parameters:
- ADDR_W, 7, table index width; depth = 2^ADDR_W entries.
- BASE_W, 20, unsigned base width; output width equals BASE_W.
- SLOPE_W, 13, unsigned slope width.
- FRAC_W, 8, unsigned interpolation fraction width.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  table write index.
- cfg_wdata  in  BASE_W+SLOPE_W  write data {base, slope}; base in the MSBs.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_x  in  ADDR_W+FRAC_W  {addr, frac}; addr in the MSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  BASE_W  interpolated, saturated result.

Behaviour:
- Reset (async assert, sync-released use): out_valid=0, out_y=0, and all pipeline valid bits are 0, so in_ready=1. Table storage is not reset; its contents are undefined until written.
- Config write: when cfg_we=1, table[cfg_addr] <= cfg_wdata at the clock edge. Writes are accepted regardless of pipeline state and are never stalled.
- Pipeline: S1 registers addr/frac; S2 reads the table and registers base/slope/frac; S3 computes the multiply, add, round and saturate into out_y/out_valid.
  - Latency: 3 cycles from an accepted input to out_valid.
  - Throughput: 1 sample per cycle.
- Read/write collision: if S1→S2 reads the same address that cfg_we is writing in that cycle, S2 gets the OLD entry (read-before-write). The new value is seen from the next cycle.
- Arithmetic (all unsigned):
  - prod = slope*frac, width SLOPE_W+FRAC_W.
  - inc = (prod + 2^(FRAC_W-1)) >> FRAC_W (round half up).
  - sum = base + inc, width BASE_W+1.
  - out_y = sum if sum < 2^BASE_W, else 2^BASE_W-1 (saturate).
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - An input is accepted iff in_valid & in_ready.
  - During stall, all stage registers, including bubbles, hold their values, and out_y/out_valid are held.
  - When not stalled, each stage advances and an empty slot propagates valid=0.
- Ordering: results leave in acceptance order. No sample is dropped or duplicated under any out_ready pattern.
- in_valid while in_ready=0: the sample is not taken; the source must hold it.
- Reset mid-operation: all in-flight samples are discarded and out_valid drops asynchronously. The table keeps its last written contents.
- frac=0 gives exactly base. The maximum frac (2^FRAC_W-1) with the maximum slope stays within the declared widths, with no overflow before saturation.

Decomposition:
- Shared package bm_pkg holds:
  - default widths ADDR_W/BASE_W/SLOPE_W/FRAC_W;
  - a packed coefficient typedef {base, slope};
  - a function computing the saturated PWL result, reused by the bench model.
- One natural sub-module: bm_coef_ram.
  - Synchronous-read, single-write-port register array of 2^ADDR_W × (BASE_W+SLOPE_W).
  - Read enable is tied to ~stall.
  - Read-before-write behaviour.

Test Plan:
- Load table[0]={524290,4080}; in_x={0,8'd0} → out_valid exactly 3 cycles later, out_y=524290.
- Same entry, frac=128 → inc=(522240+128)>>8=2040, out_y=526330. Then frac=255 → inc=(1040400+128)>>8=4064, out_y=528354.
- Load table[127]={1048575,8191}; frac=255 → sum exceeds 2^20-1, out_y=1048575 (saturated). With frac=0 → out_y=1048575 (not saturated).
- Back-to-back inputs to addrs 0,1,2,3 with out_ready held low for 5 cycles from the first out_valid:
  - in_ready=0 while stalled;
  - all 4 results appear in order with correct values;
  - no loss or duplication.
  - Repeat with random out_ready, checked against the bm_pkg model.
- Write table[5]={600000,100} in the same cycle that addr 5 is read in S1→S2 → that result uses the old entry; the next sample to addr 5 with frac=0 gives 600000.
- Drive rst_n low with 2 samples in flight → out_valid=0 immediately. After release, in_ready=1, and the first new sample returns after 3 cycles using the retained table.
